// File: rtl/req_arbiter_buffered.sv
// N:1 memory-network request arbiter: round-robin or fixed-priority selection, burst grant
// locking, and a 2-entry registered skid buffer carrying {source index, message}.
module req_arbiter_buffered #(
  parameter int unsigned p_num_arb  = 4,
  parameter int unsigned p_msg_bits = 79,
  parameter int unsigned p_mode     = 0,
  parameter int unsigned p_src_bits = (p_num_arb > 1) ? $clog2(p_num_arb) : 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [p_num_arb-1:0]              arb_val,
  output logic [p_num_arb-1:0]              arb_rdy,
  input  logic [p_num_arb-1:0]              arb_last,
  input  logic [p_num_arb*p_msg_bits-1:0]   arb_msg,
  output logic                              gnt_val,
  input  logic                              gnt_rdy,
  output logic [p_msg_bits-1:0]             gnt_msg,
  output logic [p_src_bits-1:0]             gnt_src,
  output logic                              locked
);

  typedef enum logic {UNLOCKED, LOCKED} lock_e;

  lock_e                 state_q, state_d;
  logic [p_src_bits-1:0] owner_q, owner_d;
  logic [p_src_bits-1:0] ptr_q, ptr_d;
  logic [1:0]            count_q, count_d;
  logic [p_msg_bits-1:0] msg0_q, msg0_d, msg1_q, msg1_d;
  logic [p_src_bits-1:0] src0_q, src0_d, src1_q, src1_d;

  logic                  can_accept, any_sel, xfer, pop, sel_last;
  logic [p_src_bits-1:0] sel, rr_idx;
  logic [p_msg_bits-1:0] sel_msg;

  assign can_accept = (count_q < 2'd2);
  assign gnt_val    = (count_q != 2'd0);
  assign pop        = gnt_val & gnt_rdy;
  assign gnt_msg    = msg0_q;
  assign gnt_src    = src0_q;
  assign locked     = (state_q == LOCKED);

  // Candidate selection; the lock owner is exclusive even while it is idle.
  always_comb begin
    sel      = '0;
    any_sel  = 1'b0;
    rr_idx   = '0;
    sel_msg  = '0;
    sel_last = 1'b0;
    if (state_q == LOCKED) begin
      sel     = owner_q;
      any_sel = arb_val[owner_q];
    end else if (p_mode == 1) begin
      for (int unsigned k = 0; k < p_num_arb; k++) begin
        if (!any_sel && arb_val[p_src_bits'(k)]) begin
          sel     = p_src_bits'(k);
          any_sel = 1'b1;
        end
      end
    end else begin
      for (int unsigned k = 0; k < p_num_arb; k++) begin
        rr_idx = p_src_bits'((32'(ptr_q) + k) % p_num_arb);
        if (!any_sel && arb_val[rr_idx]) begin
          sel     = rr_idx;
          any_sel = 1'b1;
        end
      end
    end
    for (int unsigned i = 0; i < p_num_arb; i++) begin
      if (p_src_bits'(i) == sel) begin
        sel_msg  = arb_msg[i*p_msg_bits +: p_msg_bits];
        sel_last = arb_last[i];
      end
    end
  end

  assign xfer = any_sel & can_accept & ~rst;

  always_comb begin
    arb_rdy = '0;
    if (xfer) arb_rdy[sel] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    if (xfer && sel_last) ptr_d = (32'(sel) == p_num_arb - 1) ? '0 : sel + 1'b1;
    case (state_q)
      UNLOCKED: if (xfer && !sel_last) begin
        state_d = LOCKED;
        owner_d = sel;
      end
      LOCKED:   if (xfer && sel_last) state_d = UNLOCKED;
      default:  state_d = UNLOCKED;
    endcase
  end

  // Shift-register FIFO: slot 0 is always the head, so the output needs no read mux.
  always_comb begin
    count_d = count_q;
    msg0_d  = msg0_q;
    msg1_d  = msg1_q;
    src0_d  = src0_q;
    src1_d  = src1_q;
    case ({xfer, pop})
      2'b10: begin
        if (count_q == 2'd0) begin
          msg0_d = sel_msg;
          src0_d = sel;
        end else begin
          msg1_d = sel_msg;
          src1_d = sel;
        end
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        msg0_d  = msg1_q;
        src0_d  = src1_q;
        count_d = count_q - 2'd1;
      end
      // Push with pop only happens at count 1, so the new beat becomes the head.
      2'b11: begin
        msg0_d = sel_msg;
        src0_d = sel;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= UNLOCKED;
      owner_q <= '0;
      ptr_q   <= '0;
      count_q <= '0;
      msg0_q  <= '0;
      msg1_q  <= '0;
      src0_q  <= '0;
      src1_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      msg0_q  <= msg0_d;
      msg1_q  <= msg1_d;
      src0_q  <= src0_d;
      src1_q  <= src1_d;
    end
  end

endmodule
